ps2_rx_deframer: RTL and testbench
==================================

# ps2_rx_deframer

Receive-side front end for the PS/2 peripheral. It takes the raw, asynchronous PS/2 clock and data lines and synchronises and glitch-filters the clock. It then deserialises each 11-bit device-to-host frame, checks start, parity and stop bits, and hands a completed frame to the PS2 register/interrupt block. Its `rx_frame` output drives that block's `bitsReceived`, and `rx_valid` is the source of its receive interrupt. It sits between the board pins and the PS2 bus-slave block, in the `Bus2IP_Clk` domain.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive `Bus2IP_Clk` cycles a synchronised PS/2 clock level must hold before the filtered clock accepts it (range 1..255).
- `TIMEOUT_CYCLES`, default 20000: maximum number of cycles between falling edges inside a frame before the frame is aborted (200 us at 100 MHz).

Ports:
- `Bus2IP_Clk` in 1: sole clock, 100 MHz.
- `Bus2IP_Resetn` in 1: reset, asynchronous, active-low.
- `ps2_clk_in` in 1: raw PS/2 clock pin, asynchronous, idles high.
- `ps2_data_in` in 1: raw PS/2 data pin, asynchronous, idles high.
- `rx_enable` in 1: high allows reception. The transmit side drives it low while the host inhibits the bus or is sending.
- `rx_data` out 8: data byte of the last completed frame.
- `rx_frame` out 11: raw last completed frame; bit 0 = start, bits 8:1 = data (LSB first), bit 9 = parity, bit 10 = stop.
- `rx_valid` out 1: one-cycle pulse for a good frame.
- `rx_parity_err` out 1: one-cycle pulse for a parity failure.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit is 0.
- `rx_timeout` out 1: one-cycle pulse when a frame is aborted by timeout.
- `rx_busy` out 1: high while a frame is in progress (state is not IDLE).

## Operation
Synchronisation and filtering:
- Both pins pass through a 2-flop synchroniser. Synchroniser flops reset to 1.
- Filtered clock `fclk` resets to 1.
- A counter counts consecutive cycles in which the synchronised clock differs from `fclk`.
  - When the count reaches `FILTER_LEN`, `fclk` takes the new level and the counter clears.
  - Any cycle in which they match clears the counter.
- A strobe is the cycle in which `fclk` goes 1→0. On a strobe, the synchronised data bit is sampled.

State machine (IDLE, SHIFT, CHECK):
- **IDLE**
  - Strobe with data = 0: capture the start bit into `frame[0]`, set bit count = 1, go to SHIFT.
  - Strobe with data = 1: ignored.
- **SHIFT**
  - Each strobe stores the sampled bit into `frame[count]` and increments `count`.
  - The strobe that stores bit 10 moves to CHECK.
  - A watchdog counter clears on every strobe. If it reaches `TIMEOUT_CYCLES`, pulse `rx_timeout`, discard the partial frame and return to IDLE.
- **CHECK** (exactly one cycle)
  - Load `rx_frame`/`rx_data` from the shift register. They are loaded for every completed frame, including errored ones, and are held until the next completion.
  - Evaluate in priority order:
    1. stop = 0: `rx_frame_err` only.
    2. Else, XOR of data bits and parity ≠ 1 (odd parity fails): `rx_parity_err` only.
    3. Else: `rx_valid`.
  - The start bit is 0 by construction. Return to IDLE.
- Exactly one of the four pulses fires per frame attempt, and never more than one in a cycle.

`rx_enable` low:
- Forces IDLE on the next cycle from any state and clears the bit count and watchdog.
- No pulse is emitted and the partial frame is lost.
- Strobes are ignored while `rx_enable` is low.
- The filter keeps running, so no false edge is generated on re-enable.

Reset:
- Reset mid-frame abandons the frame.
- All outputs go to 0, state goes to IDLE and `fclk` goes to 1.

## Timing
- Reset values: `rx_data` = 0, `rx_frame` = 0, all pulses 0, `rx_busy` = 0.
- Pin falling edge to strobe: 2 (sync) + `FILTER_LEN` cycles, ±1 for metastability resolution.
- The filter rejects any clock pulse shorter than `FILTER_LEN` cycles.
- 11th strobe at cycle N:
  - CHECK state in cycle N+1.
  - `rx_frame`/`rx_data` updated and the pulse high in cycle N+2, for exactly one cycle.
- `rx_busy` rises in the cycle after the start-bit strobe. It falls in the same cycle as the result pulse, or the timeout pulse.
- Timeout pulse: `TIMEOUT_CYCLES` cycles after the last strobe, measured inside SHIFT only.
- The PS/2 bit period is 60–100 us (6000–10000 cycles). Consecutive frames are never closer than one bit period, so CHECK never collides with a strobe.

## Test plan
- **Good frame, code 0x1C**: start 0, data 0x1C LSB first, parity 0, stop 1, at 12.5 kHz → one `rx_valid` pulse; `rx_data` = 0x1C, `rx_frame` = 0x438, no error pulses, `rx_busy` low after the pulse.
- **Parity**:
  - Data 0xF0 with parity 1 → `rx_valid`, `rx_frame` = 0x7E0.
  - Same frame with parity 0 → `rx_parity_err` only, `rx_frame` = 0x5E0.
- **Stop bit**: frame 0x1C with stop = 0 and a bad parity bit → `rx_frame_err` only (stop error outranks parity); `rx_frame` = 0x238.
- **Glitch and idle noise**:
  - 3-cycle low glitch on `ps2_clk_in` with `FILTER_LEN` = 8 → no strobe, `rx_busy` stays 0.
  - Strobe in IDLE with data 1 → ignored.
- **Timeout**: send 5 bits, then hold the clock high → `rx_timeout` pulse `TIMEOUT_CYCLES` after the 5th strobe, `rx_busy` 0. The next full 0x1C frame then decodes correctly.
- **Abort**:
  - Drop `rx_enable` after 6 bits → `rx_busy` 0 next cycle, no pulses. Re-enable, then a 0x1C frame → valid.
  - Assert reset mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_rx_deframer.sv
// PS/2 device-to-host receive front end: synchronises and filters the raw pins,
// then deserialises 11-bit frames and reports one result pulse per attempt.
module ps2_rx_deframer #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic        Bus2IP_Clk,
   input  logic        Bus2IP_Resetn,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   input  logic        rx_enable,
   output logic [7:0]  rx_data,
   output logic [10:0] rx_frame,
   output logic        rx_valid,
   output logic        rx_parity_err,
   output logic        rx_frame_err,
   output logic        rx_timeout,
   output logic        rx_busy
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   state_t            state_q, state_d;
   logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic              fclk_q, fclk_d;
   logic [7:0]        flt_cnt_q, flt_cnt_d;
   logic [3:0]        count_q, count_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [10:0]       frame_q, frame_d;
   logic [10:0]       rx_frame_q, rx_frame_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              valid_q, valid_d, perr_q, perr_d;
   logic              ferr_q, ferr_d, tout_q, tout_d;
   logic              strobe;

   always_comb begin
      state_d    = state_q;
      clk_s1_d   = ps2_clk_in;
      clk_s2_d   = clk_s1_q;
      dat_s1_d   = ps2_data_in;
      dat_s2_d   = dat_s1_q;
      fclk_d     = fclk_q;
      flt_cnt_d  = 8'd0;
      count_d    = count_q;
      wd_d       = wd_q;
      frame_d    = frame_q;
      rx_frame_d = rx_frame_q;
      rx_data_d  = rx_data_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      tout_d     = 1'b0;

      // The filter runs regardless of rx_enable so re-enabling never sees a stale edge.
      if (clk_s2_q != fclk_q) begin
         if (flt_cnt_q + 8'd1 == 8'(FILTER_LEN)) begin
            fclk_d    = clk_s2_q;
            flt_cnt_d = 8'd0;
         end else begin
            flt_cnt_d = flt_cnt_q + 8'd1;
         end
      end
      strobe = fclk_q & ~fclk_d;

      if (!rx_enable) begin
         state_d = IDLE;
         count_d = 4'd0;
         wd_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (strobe && !dat_s2_q) begin
                  frame_d = 11'd0;
                  count_d = 4'd1;
                  wd_d    = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (strobe) begin
                  frame_d[count_q] = dat_s2_q;
                  count_d          = count_q + 4'd1;
                  wd_d             = '0;
                  if (count_q == 4'd10) state_d = CHECK;
               end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  tout_d  = 1'b1;
                  count_d = 4'd0;
                  wd_d    = '0;
                  state_d = IDLE;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
            CHECK: begin
               rx_frame_d = frame_q;
               rx_data_d  = frame_q[8:1];
               // Stop error outranks parity; parity is odd over data plus parity bit.
               if (!frame_q[10])       ferr_d  = 1'b1;
               else if (!(^frame_q[9:1])) perr_d = 1'b1;
               else                    valid_d = 1'b1;
               count_d = 4'd0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         state_q    <= IDLE;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         fclk_q     <= 1'b1;
         flt_cnt_q  <= 8'd0;
         count_q    <= 4'd0;
         wd_q       <= '0;
         frame_q    <= 11'd0;
         rx_frame_q <= 11'd0;
         rx_data_q  <= 8'd0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         fclk_q     <= fclk_d;
         flt_cnt_q  <= flt_cnt_d;
         count_q    <= count_d;
         wd_q       <= wd_d;
         frame_q    <= frame_d;
         rx_frame_q <= rx_frame_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         tout_q     <= tout_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_frame      = rx_frame_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = perr_q;
   assign rx_frame_err  = ferr_q;
   assign rx_timeout    = tout_q;
   assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Directed and randomised frames against a frame-level model of the PS/2 receiver.
module tb_ps2_rx_deframer;

   localparam int FLT  = 8;
   localparam int TOUT = 300;
   localparam int HALF = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rx_enable = 1'b1;
   logic [7:0]  rx_data;
   logic [10:0] rx_frame;
   logic        rx_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Event counters written only by the monitor.
   int cyc = 0, c_valid = 0, c_perr = 0, c_ferr = 0, c_tout = 0, c_multi = 0;
   int c_rise = 0, c_fall_pulse = 0, c_fall_nopulse = 0, last_tout_cyc = 0;
   logic busy_prev = 1'b0;
   logic [3:0] pulses;

   int s_valid, s_perr, s_ferr, s_tout, s_rise, s_fp, s_fn;
   int last_fall_cyc;

   ps2_rx_deframer #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TOUT)) dut (
      .Bus2IP_Clk    (clk),
      .Bus2IP_Resetn (rst_n),
      .ps2_clk_in    (ps2_clk),
      .ps2_data_in   (ps2_data),
      .rx_enable     (rx_enable),
      .rx_data       (rx_data),
      .rx_frame      (rx_frame),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_timeout    (rx_timeout),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      pulses = {rx_valid, rx_parity_err, rx_frame_err, rx_timeout};
      if (rx_valid)      c_valid++;
      if (rx_parity_err) c_perr++;
      if (rx_frame_err)  c_ferr++;
      if (rx_timeout) begin
         c_tout++;
         last_tout_cyc = cyc;
      end
      if ($countones(pulses) > 1) c_multi++;
      if (rx_busy && !busy_prev) c_rise++;
      if (!rx_busy && busy_prev) begin
         if (pulses != 4'd0) c_fall_pulse++;
         else                c_fall_nopulse++;
      end
      busy_prev = rx_busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      s_valid = c_valid; s_perr = c_perr; s_ferr = c_ferr; s_tout = c_tout;
      s_rise = c_rise; s_fp = c_fall_pulse; s_fn = c_fall_nopulse;
   endtask

   // Device drives data while the clock is high; host samples on the falling edge.
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   // 0 = good, 1 = parity error, 2 = stop-bit error.
   function automatic int model_kind(input logic [10:0] f);
      if (f[10] == 1'b0) return 2;
      if ($countones(f[9:1]) % 2 == 1) return 0;
      return 1;
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] f;
      int k;
      f = mk_frame(d, par, stop);
      k = model_kind(f);
      snap();
      send_bits(f, 11);
      wait_cyc(30);
      check({tag, ".valid"}, c_valid - s_valid, (k == 0) ? 1 : 0);
      check({tag, ".perr"},  c_perr - s_perr,   (k == 1) ? 1 : 0);
      check({tag, ".ferr"},  c_ferr - s_ferr,   (k == 2) ? 1 : 0);
      check({tag, ".tout"},  c_tout - s_tout,   0);
      check({tag, ".frame"}, {21'd0, rx_frame}, {21'd0, f});
      check({tag, ".data"},  {24'd0, rx_data},  {24'd0, d});
      check({tag, ".busy"},  {31'd0, rx_busy},  0);
      check({tag, ".fall_with_pulse"}, c_fall_pulse - s_fp, 1);
   endtask

   initial begin
      wait_cyc(5);
      check("reset.data",  {24'd0, rx_data}, 0);
      check("reset.frame", {21'd0, rx_frame}, 0);
      check("reset.pulses", {28'd0, rx_valid, rx_parity_err, rx_frame_err, rx_timeout}, 0);
      check("reset.busy",  {31'd0, rx_busy}, 0);
      rst_n = 1'b1;
      wait_cyc(20);

      run_frame("good_1c", 8'h1C, 1'b0, 1'b1);
      check("good_1c.frame_const", {21'd0, rx_frame}, 32'h438);
      run_frame("f0_par1", 8'hF0, 1'b1, 1'b1);
      check("f0_par1.frame_const", {21'd0, rx_frame}, 32'h7E0);
      run_frame("f0_par0", 8'hF0, 1'b0, 1'b1);
      check("f0_par0.frame_const", {21'd0, rx_frame}, 32'h5E0);
      run_frame("stop0", 8'h1C, 1'b1, 1'b0);
      check("stop0.frame_const", {21'd0, rx_frame}, 32'h238);

      // Short clock glitch with data low must not look like a start bit.
      snap();
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(30);
      ps2_data = 1'b1;
      check("glitch.rise", c_rise - s_rise, 0);
      check("glitch.busy", {31'd0, rx_busy}, 0);
      send_bits(11'h7FF, 1);
      wait_cyc(30);
      check("idle_data1.rise", c_rise - s_rise, 0);

      snap();
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
      check("tmo.busy_mid", {31'd0, rx_busy}, 1);
      wait_cyc(TOUT + 40);
      check("tmo.count", c_tout - s_tout, 1);
      check("tmo.latency_ok",
            ((last_tout_cyc - last_fall_cyc >= TOUT + 6) &&
             (last_tout_cyc - last_fall_cyc <= TOUT + 16)) ? 1 : 0, 1);
      check("tmo.other", (c_valid - s_valid) + (c_perr - s_perr) + (c_ferr - s_ferr), 0);
      check("tmo.busy", {31'd0, rx_busy}, 0);
      run_frame("after_tmo", 8'h1C, 1'b0, 1'b1);

      snap();
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 6);
      check("abort.busy_mid", {31'd0, rx_busy}, 1);
      rx_enable = 1'b0;
      wait_cyc(1);
      check("abort.busy_next", {31'd0, rx_busy}, 0);
      wait_cyc(HALF);
      check("abort.pulses", (c_valid - s_valid) + (c_perr - s_perr) + (c_ferr - s_ferr) + (c_tout - s_tout), 0);
      check("abort.fall_nopulse", c_fall_nopulse - s_fn, 1);
      rx_enable = 1'b1;
      wait_cyc(HALF);
      run_frame("after_abort", 8'h1C, 1'b0, 1'b1);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         logic p, s;
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) != 0);
         run_frame($sformatf("rand%0d", i), d, p, s);
      end

      run_frame("pre_reset", 8'h1C, 1'b0, 1'b1);
      send_bits(mk_frame(8'h55, 1'b1, 1'b1), 4);
      check("rst_mid.busy_before", {31'd0, rx_busy}, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid.data",  {24'd0, rx_data}, 0);
      check("rst_mid.frame", {21'd0, rx_frame}, 0);
      check("rst_mid.busy",  {31'd0, rx_busy}, 0);
      check("rst_mid.pulses", {28'd0, rx_valid, rx_parity_err, rx_frame_err, rx_timeout}, 0);
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(20);
      check("never_multi_pulse", c_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

endmodule
